// File: rtl/riscv_lsu_pkg.sv
// Shared load/store function encodings and access-size helpers for the LSU.
// Contents:
//   LD_FUNCT_W / ST_FUNCT_W   widths of the EX->MEM load and store function fields
//   LD_* / ST_*               load and store encodings (*_NOP marks a plain ALU op)
//   acc_size_e                access width decoded from the function fields
//   access_size()             decode helper; a non-NOP load wins over a store
//   is_misaligned()           natural-alignment check for a given access width
package riscv_lsu_pkg;

  localparam int unsigned LD_FUNCT_W = 3;
  localparam int unsigned ST_FUNCT_W = 2;

  localparam logic [LD_FUNCT_W-1:0] LD_NOP = 3'd0;
  localparam logic [LD_FUNCT_W-1:0] LD_LB  = 3'd1;
  localparam logic [LD_FUNCT_W-1:0] LD_LH  = 3'd2;
  localparam logic [LD_FUNCT_W-1:0] LD_LW  = 3'd3;
  localparam logic [LD_FUNCT_W-1:0] LD_LBU = 3'd4;
  localparam logic [LD_FUNCT_W-1:0] LD_LHU = 3'd5;

  localparam logic [ST_FUNCT_W-1:0] ST_NOP = 2'd0;
  localparam logic [ST_FUNCT_W-1:0] ST_SB  = 2'd1;
  localparam logic [ST_FUNCT_W-1:0] ST_SH  = 2'd2;
  localparam logic [ST_FUNCT_W-1:0] ST_SW  = 2'd3;

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} acc_size_e;

  function automatic acc_size_e access_size(input logic [LD_FUNCT_W-1:0] ld_funct,
                                            input logic [ST_FUNCT_W-1:0] st_funct);
    acc_size_e size;
    size = SzByte;
    if (ld_funct != LD_NOP) begin
      case (ld_funct)
        LD_LH, LD_LHU: size = SzHalf;
        LD_LW:         size = SzWord;
        default:       size = SzByte;
      endcase
    end else begin
      case (st_funct)
        ST_SH:   size = SzHalf;
        ST_SW:   size = SzWord;
        default: size = SzByte;
      endcase
    end
    return size;
  endfunction

  function automatic logic is_misaligned(input acc_size_e size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SzHalf:  mis = addr_lo[0];
      SzWord:  mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-enable generation and store-data lane replication (purely combinational).
// Ports:
//   ld_funct, st_funct  in   op function fields (a non-NOP load takes precedence)
//   addr_lo             in   effective address bits [1:0]
//   wdata               in   raw store data from EX
//   be                  out  byte enables (all ones for loads)
//   wdata_rep           out  store data replicated across the byte lanes
//   offset              out  byte offset truncated to the access size
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [LD_FUNCT_W-1:0] ld_funct,
  input  logic [ST_FUNCT_W-1:0] st_funct,
  input  logic [1:0]            addr_lo,
  input  logic [31:0]           wdata,
  output logic [3:0]            be,
  output logic [31:0]           wdata_rep,
  output logic [1:0]            offset
);

  acc_size_e size;

  always_comb begin
    size      = access_size(ld_funct, st_funct);
    offset    = 2'b00;
    be        = 4'b1111;
    wdata_rep = wdata;
    case (size)
      SzByte: begin
        offset    = addr_lo;
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SzHalf: begin
        // Dropping addr_lo[0] is what truncates a misaligned halfword.
        offset    = {addr_lo[1], 1'b0};
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        offset    = 2'b00;
        be        = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
    // Loads always fetch the whole word; WB extracts the lane via mem_wb_baddr.
    if (ld_funct != LD_NOP) begin
      be = 4'b1111;
    end
  end

endmodule

// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: single-entry holding register between EX and WB that
// drives a simple request/acknowledge data bus.
// Ports:
//   clk, rstn                 clock (rising edge), asynchronous active-low reset
//   us_rdy / us_ack           upstream (EX) handshake; us_ack is the only
//                             combinational output
//   ex_mem_*                  op from EX: load/store function, address, store
//                             data, ALU result, destination register
//   data_bif_*                data bus: req/we/addr/be/wdata out, ack in
//   ds_rdy / ds_ack           downstream (WB) handshake
//   mem_wb_*                  op presented to WB: load type, data, rd, byte offset
//   mem_misalign              one-cycle misalignment fault pulse
// Build option: define RISCV_MISALIGN_TRAP_EN to trap misaligned halfword/word
// accesses instead of silently truncating the low address bits.
module riscv_lsu
  import riscv_lsu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  us_rdy,
  output logic                  us_ack,
  input  logic [LD_FUNCT_W-1:0] ex_mem_ld_funct,
  input  logic [ST_FUNCT_W-1:0] ex_mem_st_funct,
  input  logic [31:0]           ex_mem_addr,
  input  logic [31:0]           ex_mem_wdata,
  input  logic [31:0]           ex_mem_data,
  input  logic [4:0]            ex_mem_rsd,
  output logic                  data_bif_req,
  output logic                  data_bif_we,
  output logic [31:0]           data_bif_addr,
  output logic [3:0]            data_bif_be,
  output logic [31:0]           data_bif_wdata,
  input  logic                  data_bif_ack,
  output logic                  ds_rdy,
  input  logic                  ds_ack,
  output logic [LD_FUNCT_W-1:0] mem_wb_funct,
  output logic [31:0]           mem_wb_data,
  output logic [4:0]            mem_wb_rsd,
  output logic [1:0]            mem_wb_baddr,
  output logic                  mem_misalign
);

  typedef enum logic [1:0] {StIdle, StLoad, StStore, StPass} state_e;

  state_e state_q, state_d, op_state;

  logic is_ld, is_st, mis, accept;

  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [1:0]  align_offset;

  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic                  ds_rdy_q, ds_rdy_d;
  logic [31:0]           bif_addr_q, bif_addr_d;
  logic [3:0]            bif_be_q, bif_be_d;
  logic [31:0]           bif_wdata_q, bif_wdata_d;
  logic [LD_FUNCT_W-1:0] wb_funct_q, wb_funct_d;
  logic [31:0]           wb_data_q, wb_data_d;
  logic [4:0]            wb_rsd_q, wb_rsd_d;
  logic [1:0]            wb_baddr_q, wb_baddr_d;

  // A store is only a store when no load is requested alongside it.
  assign is_ld = (ex_mem_ld_funct != LD_NOP);
  assign is_st = !is_ld && (ex_mem_st_funct != ST_NOP);

`ifdef RISCV_MISALIGN_TRAP_EN
  assign mis = (is_ld || is_st) &&
               is_misaligned(access_size(ex_mem_ld_funct, ex_mem_st_funct), ex_mem_addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  riscv_lsu_align u_align (
    .ld_funct  (ex_mem_ld_funct),
    .st_funct  (ex_mem_st_funct),
    .addr_lo   (ex_mem_addr[1:0]),
    .wdata     (ex_mem_wdata),
    .be        (align_be),
    .wdata_rep (align_wdata),
    .offset    (align_offset)
  );

  // Upstream acknowledge: free slot, or the held op retires this cycle.
  always_comb begin
    us_ack = 1'b0;
    unique case (state_q)
      StIdle:         us_ack = 1'b1;
      StLoad, StPass: us_ack = ds_ack;
      StStore:        us_ack = 1'b0;
    endcase
  end

  assign accept = us_rdy && us_ack;

  // State register plus the registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      ds_rdy_q    <= 1'b0;
      bif_addr_q  <= 32'h0;
      bif_be_q    <= 4'h0;
      bif_wdata_q <= 32'h0;
      wb_funct_q  <= LD_NOP;
      wb_data_q   <= 32'h0;
      wb_rsd_q    <= 5'd0;
      wb_baddr_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      ds_rdy_q    <= ds_rdy_d;
      bif_addr_q  <= bif_addr_d;
      bif_be_q    <= bif_be_d;
      bif_wdata_q <= bif_wdata_d;
      wb_funct_q  <= wb_funct_d;
      wb_data_q   <= wb_data_d;
      wb_rsd_q    <= wb_rsd_d;
      wb_baddr_q  <= wb_baddr_d;
    end
  end

  // Next state. Retiring with a new op waiting dispatches it in the same cycle.
  always_comb begin
    op_state = StPass;
    if (mis) begin
      op_state = StPass;
    end else if (is_ld) begin
      op_state = StLoad;
    end else if (is_st) begin
      op_state = StStore;
    end

    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (us_rdy) state_d = op_state;
      end
      StLoad, StPass: begin
        if (ds_ack) state_d = us_rdy ? op_state : StIdle;
      end
      StStore: begin
        if (data_bif_ack) state_d = StPass;
      end
    endcase
  end

  // Next values of the registered outputs. Op fields only change on accept,
  // which keeps the bus address/data stable for the whole request.
  always_comb begin
    req_d    = (state_d == StLoad) || (state_d == StStore);
    we_d     = (state_d == StStore);
    ds_rdy_d = (state_d == StLoad) || (state_d == StPass);

    bif_addr_d  = bif_addr_q;
    bif_be_d    = bif_be_q;
    bif_wdata_d = bif_wdata_q;
    wb_funct_d  = wb_funct_q;
    wb_data_d   = wb_data_q;
    wb_rsd_d    = wb_rsd_q;
    wb_baddr_d  = wb_baddr_q;

    if (accept) begin
      bif_addr_d  = {ex_mem_addr[31:2], 2'b00};
      bif_be_d    = align_be;
      bif_wdata_d = align_wdata;
      wb_data_d   = ex_mem_data;
      wb_baddr_d  = align_offset;
      // Stores and trapped ops retire through WB as a no-op writing x0.
      wb_funct_d  = (is_ld && !mis) ? ex_mem_ld_funct : LD_NOP;
      wb_rsd_d    = (is_st || mis) ? 5'd0 : ex_mem_rsd;
    end
  end

  assign data_bif_req   = req_q;
  assign data_bif_we    = we_q;
  assign data_bif_addr  = bif_addr_q;
  assign data_bif_be    = bif_be_q;
  assign data_bif_wdata = bif_wdata_q;
  assign ds_rdy         = ds_rdy_q;
  assign mem_wb_funct   = wb_funct_q;
  assign mem_wb_data    = wb_data_q;
  assign mem_wb_rsd     = wb_rsd_q;
  assign mem_wb_baddr   = wb_baddr_q;

`ifdef RISCV_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= accept && mis;
    end
  end

  assign mem_misalign = misalign_q;
`else
  assign mem_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu.
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;

  logic                  clk, rstn;
  logic                  us_rdy, us_ack;
  logic [LD_FUNCT_W-1:0] ex_mem_ld_funct;
  logic [ST_FUNCT_W-1:0] ex_mem_st_funct;
  logic [31:0]           ex_mem_addr, ex_mem_wdata, ex_mem_data;
  logic [4:0]            ex_mem_rsd;
  logic                  data_bif_req, data_bif_we, data_bif_ack;
  logic [31:0]           data_bif_addr, data_bif_wdata;
  logic [3:0]            data_bif_be;
  logic                  ds_rdy, ds_ack;
  logic [LD_FUNCT_W-1:0] mem_wb_funct;
  logic [31:0]           mem_wb_data;
  logic [4:0]            mem_wb_rsd;
  logic [1:0]            mem_wb_baddr;
  logic                  mem_misalign;

  int checks = 0;
  int errors = 0;

  riscv_lsu dut (
    .clk             (clk),
    .rstn            (rstn),
    .us_rdy          (us_rdy),
    .us_ack          (us_ack),
    .ex_mem_ld_funct (ex_mem_ld_funct),
    .ex_mem_st_funct (ex_mem_st_funct),
    .ex_mem_addr     (ex_mem_addr),
    .ex_mem_wdata    (ex_mem_wdata),
    .ex_mem_data     (ex_mem_data),
    .ex_mem_rsd      (ex_mem_rsd),
    .data_bif_req    (data_bif_req),
    .data_bif_we     (data_bif_we),
    .data_bif_addr   (data_bif_addr),
    .data_bif_be     (data_bif_be),
    .data_bif_wdata  (data_bif_wdata),
    .data_bif_ack    (data_bif_ack),
    .ds_rdy          (ds_rdy),
    .ds_ack          (ds_ack),
    .mem_wb_funct    (mem_wb_funct),
    .mem_wb_data     (mem_wb_data),
    .mem_wb_rsd      (mem_wb_rsd),
    .mem_wb_baddr    (mem_wb_baddr),
    .mem_misalign    (mem_misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish within 200000");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    us_rdy = 1'b0; ex_mem_ld_funct = LD_NOP; ex_mem_st_funct = ST_NOP;
    ex_mem_addr = 32'h0; ex_mem_wdata = 32'h0; ex_mem_data = 32'h0; ex_mem_rsd = 5'd0;
    data_bif_ack = 1'b0; ds_ack = 1'b0;
  endtask

  task automatic drive_op(input logic [LD_FUNCT_W-1:0] ld, input logic [ST_FUNCT_W-1:0] st,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] d,
                          input logic [4:0] r);
    us_rdy = 1'b1; ex_mem_ld_funct = ld; ex_mem_st_funct = st;
    ex_mem_addr = a; ex_mem_wdata = wd; ex_mem_data = d; ex_mem_rsd = r;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    #3;
    checks++; if (data_bif_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", data_bif_req); end
    checks++; if (ds_rdy !== 1'b0) begin errors++; $display("FAIL rst_ds_rdy: got %b want 0", ds_rdy); end
    checks++; if (mem_wb_funct !== LD_NOP) begin errors++; $display("FAIL rst_funct: got %h want %h", mem_wb_funct, LD_NOP); end
    checks++; if ({data_bif_addr, data_bif_wdata, data_bif_be, data_bif_we} !== 69'h0) begin errors++; $display("FAIL rst_bus: got %h/%h/%h/%b want 0", data_bif_addr, data_bif_wdata, data_bif_be, data_bif_we); end
    checks++; if ({mem_wb_data, mem_wb_rsd, mem_wb_baddr, mem_misalign} !== 40'h0) begin errors++; $display("FAIL rst_wb: got %h/%h/%h/%b want 0", mem_wb_data, mem_wb_rsd, mem_wb_baddr, mem_misalign); end
    checks++; if (us_ack !== 1'b1) begin errors++; $display("FAIL rst_us_ack: got %b want 1", us_ack); end
    #5 rstn = 1'b1;
    // Bus ack while idle must not start anything.
    data_bif_ack = 1'b1;
    step();
    data_bif_ack = 1'b0;
    checks++; if (data_bif_req !== 1'b0 || ds_rdy !== 1'b0) begin errors++; $display("FAIL idle_ack_ignored: got req=%b rdy=%b want 0/0", data_bif_req, ds_rdy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    ds_ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      d = 32'h1000_0000 * i + 32'h0000_0111 * i;
      drive_op(LD_NOP, ST_NOP, 32'hFFFF_FFF0, 32'h0, d, 5'(i));
      #1;
      checks++; if (us_ack !== 1'b1) begin errors++; $display("FAIL b2b_us_ack[%0d]: got %b want 1", i, us_ack); end
      step();
      checks++; if (ds_rdy !== 1'b1) begin errors++; $display("FAIL b2b_ds_rdy[%0d]: got %b want 1", i, ds_rdy); end
      checks++; if (mem_wb_rsd !== 5'(i)) begin errors++; $display("FAIL b2b_rsd[%0d]: got %0d want %0d", i, mem_wb_rsd, i); end
      checks++; if (mem_wb_data !== d) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, mem_wb_data, d); end
      checks++; if (data_bif_req !== 1'b0) begin errors++; $display("FAIL b2b_req[%0d]: got %b want 0", i, data_bif_req); end
      checks++; if (mem_wb_funct !== LD_NOP) begin errors++; $display("FAIL b2b_funct[%0d]: got %h want 0", i, mem_wb_funct); end
    end
    us_rdy = 1'b0;
    step();
    ds_ack = 1'b0;
    checks++; if (ds_rdy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", ds_rdy); end
  endtask

  task automatic test_stall();
    drive_op(LD_NOP, ST_NOP, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd7);
    ds_ack = 1'b0;
    step();
    // New op waiting upstream must not disturb the held one.
    drive_op(LD_NOP, ST_NOP, 32'h0, 32'h0, 32'h0000_0000, 5'd9);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (us_ack !== 1'b0) begin errors++; $display("FAIL stall_us_ack[%0d]: got %b want 0", c, us_ack); end
      checks++; if (ds_rdy !== 1'b1 || mem_wb_rsd !== 5'd7 || mem_wb_data !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL stall_hold[%0d]: got rdy=%b rsd=%0d data=%h want 1/7/deadbeef", c, ds_rdy, mem_wb_rsd, mem_wb_data);
      end
      step();
    end
    us_rdy = 1'b0; ds_ack = 1'b1;
    step();
    ds_ack = 1'b0;
    checks++; if (ds_rdy !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", ds_rdy); end
  endtask

  task automatic test_load();
    int reqs;
    reqs = 0;
    drive_op(LD_LW, ST_NOP, 32'h0000_2000, 32'h0, 32'h0, 5'd5);
    ds_ack = 1'b0;
    step();
    us_rdy = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        drive_op(LD_NOP, ST_NOP, 32'h0, 32'h0, 32'h0000_0066, 5'd6);
        data_bif_ack = 1'b1; ds_ack = 1'b1;
      end
      #1;
      if (data_bif_req === 1'b1) reqs++;
      checks++; if (us_ack !== (c == 3)) begin errors++; $display("FAIL ld_us_ack[%0d]: got %b want %b", c, us_ack, c == 3); end
      checks++; if (mem_wb_funct !== LD_LW || mem_wb_rsd !== 5'd5 || ds_rdy !== 1'b1) begin
        errors++; $display("FAIL ld_wb[%0d]: got funct=%h rsd=%0d rdy=%b want 3/5/1", c, mem_wb_funct, mem_wb_rsd, ds_rdy);
      end
      checks++; if (data_bif_addr !== 32'h0000_2000 || data_bif_be !== 4'b1111 || data_bif_we !== 1'b0) begin
        errors++; $display("FAIL ld_bus[%0d]: got addr=%h be=%b we=%b want 00002000/1111/0", c, data_bif_addr, data_bif_be, data_bif_we);
      end
      step();
    end
    data_bif_ack = 1'b0; ds_ack = 1'b0; us_rdy = 1'b0;
    checks++; if (reqs !== 3) begin errors++; $display("FAIL ld_req_cycles: got %0d want 3", reqs); end
    checks++; if (data_bif_req !== 1'b0 || ds_rdy !== 1'b1 || mem_wb_rsd !== 5'd6 || mem_wb_data !== 32'h66 || mem_wb_funct !== LD_NOP) begin
      errors++; $display("FAIL ld_next_op: got req=%b rdy=%b rsd=%0d data=%h funct=%h want 0/1/6/66/0", data_bif_req, ds_rdy, mem_wb_rsd, mem_wb_data, mem_wb_funct);
    end
    ds_ack = 1'b1;
    step();
    // Byte load: byte offset reaches WB untruncated.
    drive_op(LD_LBU, ST_NOP, 32'h0000_3001, 32'h0, 32'h0, 5'd9);
    step();
    us_rdy = 1'b0;
    checks++; if (mem_wb_baddr !== 2'd1 || mem_wb_funct !== LD_LBU || data_bif_addr !== 32'h3000 || data_bif_be !== 4'b1111) begin
      errors++; $display("FAIL lbu: got baddr=%0d funct=%h addr=%h be=%b want 1/4/00003000/1111", mem_wb_baddr, mem_wb_funct, data_bif_addr, data_bif_be);
    end
    step();
    ds_ack = 1'b0;
    checks++; if (ds_rdy !== 1'b0) begin errors++; $display("FAIL lbu_retire: got %b want 0", ds_rdy); end
  endtask

  task automatic test_store();
    logic [ST_FUNCT_W-1:0] st_tab [3];
    logic [31:0] a_tab [3], wd_tab [3], ba_tab [3], rep_tab [3];
    logic [3:0]  be_tab [3];
    st_tab = '{ST_SB, ST_SH, ST_SW};
    a_tab  = '{32'h0000_1003, 32'h0000_1002, 32'h0000_1004};
    wd_tab = '{32'h0000_00AB, 32'h1234_CDEF, 32'h89AB_CDEF};
    ba_tab = '{32'h0000_1000, 32'h0000_1000, 32'h0000_1004};
    be_tab = '{4'b1000, 4'b1100, 4'b1111};
    rep_tab = '{32'hABAB_ABAB, 32'hCDEF_CDEF, 32'h89AB_CDEF};
    for (int i = 0; i < 3; i++) begin
      drive_op(LD_NOP, st_tab[i], a_tab[i], wd_tab[i], 32'h55, 5'd4);
      step();
      us_rdy = 1'b0;
      #1;
      checks++; if (data_bif_req !== 1'b1 || data_bif_we !== 1'b1 || ds_rdy !== 1'b0 || us_ack !== 1'b0) begin
        errors++; $display("FAIL st_ctl[%0d]: got req=%b we=%b rdy=%b usack=%b want 1/1/0/0", i, data_bif_req, data_bif_we, ds_rdy, us_ack);
      end
      checks++; if (data_bif_addr !== ba_tab[i] || data_bif_be !== be_tab[i] || data_bif_wdata !== rep_tab[i]) begin
        errors++; $display("FAIL st_bus[%0d]: got addr=%h be=%b wdata=%h want %h/%b/%h", i, data_bif_addr, data_bif_be, data_bif_wdata, ba_tab[i], be_tab[i], rep_tab[i]);
      end
      step();
      checks++; if (data_bif_req !== 1'b1 || ds_rdy !== 1'b0) begin errors++; $display("FAIL st_wait[%0d]: got req=%b rdy=%b want 1/0", i, data_bif_req, ds_rdy); end
      data_bif_ack = 1'b1;
      step();
      checks++; if (data_bif_req !== 1'b0 || ds_rdy !== 1'b1 || mem_wb_rsd !== 5'd0 || mem_wb_funct !== LD_NOP) begin
        errors++; $display("FAIL st_pass[%0d]: got req=%b rdy=%b rsd=%0d funct=%h want 0/1/0/0", i, data_bif_req, ds_rdy, mem_wb_rsd, mem_wb_funct);
      end
      // Bus ack in PASS is ignored; only ds_ack retires.
      step();
      data_bif_ack = 1'b0;
      checks++; if (ds_rdy !== 1'b1 || data_bif_req !== 1'b0) begin errors++; $display("FAIL st_pass_ack[%0d]: got rdy=%b req=%b want 1/0", i, ds_rdy, data_bif_req); end
      ds_ack = 1'b1;
      step();
      ds_ack = 1'b0;
      checks++; if (ds_rdy !== 1'b0) begin errors++; $display("FAIL st_retire[%0d]: got %b want 0", i, ds_rdy); end
    end
  endtask

  task automatic test_misalign();
    drive_op(LD_LW, ST_NOP, 32'h0000_2002, 32'h0, 32'h0, 5'd8);
    step();
    us_rdy = 1'b0;
`ifdef RISCV_MISALIGN_TRAP_EN
    checks++; if (mem_misalign !== 1'b1 || data_bif_req !== 1'b0) begin errors++; $display("FAIL mis_trap: got mis=%b req=%b want 1/0", mem_misalign, data_bif_req); end
    checks++; if (ds_rdy !== 1'b1 || mem_wb_funct !== LD_NOP || mem_wb_rsd !== 5'd0) begin
      errors++; $display("FAIL mis_pass: got rdy=%b funct=%h rsd=%0d want 1/0/0", ds_rdy, mem_wb_funct, mem_wb_rsd);
    end
    step();
    checks++; if (mem_misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b want 0", mem_misalign); end
`else
    checks++; if (mem_misalign !== 1'b0 || data_bif_req !== 1'b1) begin errors++; $display("FAIL mis_notrap: got mis=%b req=%b want 0/1", mem_misalign, data_bif_req); end
    checks++; if (data_bif_addr !== 32'h2000 || data_bif_be !== 4'b1111 || mem_wb_baddr !== 2'd0 || mem_wb_funct !== LD_LW || mem_wb_rsd !== 5'd8) begin
      errors++; $display("FAIL mis_trunc: got addr=%h be=%b baddr=%0d funct=%h rsd=%0d want 00002000/1111/0/3/8", data_bif_addr, data_bif_be, mem_wb_baddr, mem_wb_funct, mem_wb_rsd);
    end
`endif
    ds_ack = 1'b1;
    step();
    ds_ack = 1'b0;
    checks++; if (ds_rdy !== 1'b0 || data_bif_req !== 1'b0) begin errors++; $display("FAIL mis_retire: got rdy=%b req=%b want 0/0", ds_rdy, data_bif_req); end
  endtask

  task automatic test_reset_mid_load();
    drive_op(LD_LW, ST_NOP, 32'h0000_4000, 32'h0, 32'h0, 5'd3);
    step();
    us_rdy = 1'b0;
    checks++; if (data_bif_req !== 1'b1 || ds_rdy !== 1'b1) begin errors++; $display("FAIL rml_pre: got req=%b rdy=%b want 1/1", data_bif_req, ds_rdy); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (data_bif_req !== 1'b0 || ds_rdy !== 1'b0) begin errors++; $display("FAIL rml_drop: got req=%b rdy=%b want 0/0", data_bif_req, ds_rdy); end
    checks++; if (mem_wb_funct !== LD_NOP || us_ack !== 1'b1) begin errors++; $display("FAIL rml_idle: got funct=%h usack=%b want 0/1", mem_wb_funct, us_ack); end
    step();
    #2 rstn = 1'b1;
    step();
    checks++; if (data_bif_req !== 1'b0 || ds_rdy !== 1'b0) begin errors++; $display("FAIL rml_after: got req=%b rdy=%b want 0/0", data_bif_req, ds_rdy); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_load();
    test_store();
    test_misalign();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
